// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/
// writeback and decodes datapath controls from the current state and the IR opcode fields.
module mc_ctrl_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RFWr,
  output logic             DMWr,
  output logic [1:0]       EXTOp,
  output logic [2:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic             BSel,
  output logic [1:0]       WDSel,
  output logic [1:0]       GPRSel,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExe    = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;

  localparam logic [2:0] AluNop = 3'd0;
  localparam logic [2:0] AluAdd = 3'd1;
  localparam logic [2:0] AluSub = 3'd2;
  localparam logic [2:0] AluAnd = 3'd3;
  localparam logic [2:0] AluOr  = 3'd4;
  localparam logic [2:0] AluSlt = 3'd5;

  localparam logic [1:0] ExtZero    = 2'b00;
  localparam logic [1:0] ExtSigned  = 2'b01;
  localparam logic [1:0] ExtHighPos = 2'b10;

  localparam logic [1:0] NpcPc4    = 2'b00;
  localparam logic [1:0] NpcBranch = 2'b01;
  localparam logic [1:0] NpcJump   = 2'b10;

  localparam logic [1:0] WdAlu = 2'b00;
  localparam logic [1:0] WdMem = 2'b01;
  localparam logic [1:0] WdPc  = 2'b10;

  localparam logic [1:0] GprRd  = 2'b00;
  localparam logic [1:0] GprRt  = 2'b01;
  localparam logic [1:0] GprR31 = 2'b10;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       pc_wr, ir_wr, rf_wr, dm_wr;
  logic       is_rtype, r_legal;
  logic [2:0] alu_r;

  assign is_rtype = (Op == OpRType);

  always_comb begin
    r_legal = 1'b1;
    alu_r   = AluNop;
    case (Funct)
      FnAddu:  alu_r = AluAdd;
      FnSubu:  alu_r = AluSub;
      FnAnd:   alu_r = AluAnd;
      FnOr:    alu_r = AluOr;
      FnSlt:   alu_r = AluSlt;
      default: r_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (Op)
      OpLui:   EXTOp = ExtHighPos;
      OpOri:   EXTOp = ExtZero;
      default: EXTOp = ExtSigned;
    endcase
  end

  always_comb begin
    state_d   = StFetch;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    pc_wr     = 1'b0;
    ir_wr     = 1'b0;
    rf_wr     = 1'b0;
    dm_wr     = 1'b0;
    ALUOp     = AluNop;
    NPCOp     = NpcPc4;
    BSel      = 1'b0;
    WDSel     = WdAlu;
    GPRSel    = GprRd;

    case (state_q)
      StFetch: begin
        pc_wr   = 1'b1;
        ir_wr   = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        case (Op)
          OpLw, OpSw:             state_d = StMemAdr;
          OpOri, OpAddiu, OpLui:  state_d = StExe;
          OpBeq:                  state_d = StBranch;
          OpJ, OpJal:             state_d = StJump;
          OpRType: begin
            if (r_legal) begin
              state_d = StExe;
            end else begin
              illegal_d = 1'b1;
            end
          end
          default:                illegal_d = 1'b1;
        endcase
      end
      StMemAdr: begin
        ALUOp   = AluAdd;
        BSel    = 1'b1;
        state_d = (Op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: state_d = StMemWb;
      StMemWb: begin
        rf_wr  = 1'b1;
        WDSel  = WdMem;
        GPRSel = GprRt;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      StMemWr: begin
        dm_wr = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
      end
      StExe: begin
        // lui reuses OR: the datapath forces rs=$0 so the result is just Imm32
        if (is_rtype) begin
          ALUOp = alu_r;
        end else begin
          ALUOp = (Op == OpAddiu) ? AluAdd : AluOr;
          BSel  = 1'b1;
        end
        state_d = StAluWb;
      end
      StAluWb: begin
        rf_wr  = 1'b1;
        GPRSel = is_rtype ? GprRd : GprRt;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      StBranch: begin
        ALUOp = AluSub;
        NPCOp = NpcBranch;
        pc_wr = Zero;
        cnt_d = cnt_q + CNT_W'(1);
      end
      StJump: begin
        NPCOp = NpcJump;
        pc_wr = 1'b1;
        if (Op == OpJal) begin
          rf_wr  = 1'b1;
          GPRSel = GprR31;
          WDSel  = WdPc;
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // Strobes are gated by rst so a reset mid-instruction kills any pending write at once
  assign PCWr      = pc_wr & rst;
  assign IRWr      = ir_wr & rst;
  assign RFWr      = rf_wr & rst;
  assign DMWr      = dm_wr & rst;
  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboarded bench for mc_ctrl_fsm: directed instructions push hand-computed per-cycle
// expectations; a monitor pops and compares on every sample point.
module tb_mc_ctrl_fsm;

  localparam int unsigned CntW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [5:0]      op = 6'd0;
  logic [5:0]      funct = 6'd0;
  logic            zero = 1'b0;
  logic            pc_wr, ir_wr, rf_wr, dm_wr, bsel, illegal;
  logic [1:0]      ext_op, npc_op, wd_sel, gpr_sel;
  logic [2:0]      alu_op;
  logic [CntW-1:0] instr_cnt;
  logic [3:0]      state;

  mc_ctrl_fsm #(.CNT_W(CntW)) dut (
    .clk       (clk),
    .rst       (rst),
    .Op        (op),
    .Funct     (funct),
    .Zero      (zero),
    .PCWr      (pc_wr),
    .IRWr      (ir_wr),
    .RFWr      (rf_wr),
    .DMWr      (dm_wr),
    .EXTOp     (ext_op),
    .ALUOp     (alu_op),
    .NPCOp     (npc_op),
    .BSel      (bsel),
    .WDSel     (wd_sel),
    .GPRSel    (gpr_sel),
    .illegal   (illegal),
    .instr_cnt (instr_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  // {state, PCWr IRWr RFWr DMWr, EXTOp, ALUOp, NPCOp, BSel, WDSel, GPRSel, illegal, instr_cnt}
  typedef struct {
    string       name;
    logic [52:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [52:0] act;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        exp_ill = 1'b0;
  logic [31:0] exp_cnt = 32'd0;
  logic        sample_tog = 1'b0;

  always @(negedge clk or sample_tog) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      act = {state, pc_wr, ir_wr, rf_wr, dm_wr, ext_op, alu_op, npc_op, bsel, wd_sel,
             gpr_sel, illegal, instr_cnt};
      n_tests++;
      if (act !== mon_e.v) begin
        n_fail++;
        $display("FAIL %s: got st=%0d ctl=%h ill=%b cnt=%0d, want st=%0d ctl=%h ill=%b cnt=%0d",
                 mon_e.name, act[52:49], act[48:33], act[32], act[31:0],
                 mon_e.v[52:49], mon_e.v[48:33], mon_e.v[32], mon_e.v[31:0]);
      end
    end
  end

  task automatic push(input string nm, input logic [3:0] st, input logic [3:0] strb,
                      input logic [1:0] ext, input logic [2:0] alu, input logic [1:0] npc,
                      input logic b, input logic [1:0] wd, input logic [1:0] gpr);
    exp_t e;
    e.name = nm;
    e.v = {st, strb, ext, alu, npc, b, wd, gpr, exp_ill, exp_cnt};
    exp_q.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic [3:0] st, input logic [3:0] strb,
                     input logic [1:0] ext, input logic [2:0] alu, input logic [1:0] npc,
                     input logic b, input logic [1:0] wd, input logic [1:0] gpr);
    push(nm, st, strb, ext, alu, npc, b, wd, gpr);
    @(posedge clk);
    #1;
  endtask

  task automatic fd(input string nm, input logic [1:0] e);
    cyc({nm, "/fetch"}, 4'd0, 4'b1100, e, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00);
    cyc({nm, "/decode"}, 4'd1, 4'b0000, e, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic do_lw();
    op = 6'b100011;
    fd("lw", 2'b01);
    cyc("lw/memadr", 4'd2, 4'b0000, 2'b01, 3'd1, 2'b00, 1'b1, 2'b00, 2'b00);
    cyc("lw/memrd", 4'd3, 4'b0000, 2'b01, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00);
    cyc("lw/memwb", 4'd4, 4'b0010, 2'b01, 3'd0, 2'b00, 1'b0, 2'b01, 2'b01);
    exp_cnt++;
  endtask

  task automatic do_sw(input bit abort);
    op = 6'b101011;
    fd("sw", 2'b01);
    cyc("sw/memadr", 4'd2, 4'b0000, 2'b01, 3'd1, 2'b00, 1'b1, 2'b00, 2'b00);
    if (!abort) begin
      cyc("sw/memwr", 4'd5, 4'b0001, 2'b01, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00);
      exp_cnt++;
    end else begin
      push("sw/memwr", 4'd5, 4'b0001, 2'b01, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00);
      @(negedge clk);
      #1;
      rst = 1'b0;
      exp_ill = 1'b0;
      exp_cnt = 32'd0;
      #1;
      push("sw/abort", 4'd0, 4'b0000, 2'b01, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00);
      sample_tog = ~sample_tog;
      @(posedge clk);
      #1;
      rst = 1'b1;
    end
  endtask

  task automatic do_r(input string nm, input logic [5:0] f, input logic [2:0] alu);
    op = 6'b000000;
    funct = f;
    fd(nm, 2'b01);
    cyc({nm, "/exe"}, 4'd6, 4'b0000, 2'b01, alu, 2'b00, 1'b0, 2'b00, 2'b00);
    cyc({nm, "/aluwb"}, 4'd7, 4'b0010, 2'b01, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00);
    exp_cnt++;
  endtask

  task automatic do_i(input string nm, input logic [5:0] o, input logic [1:0] e,
                      input logic [2:0] alu);
    op = o;
    fd(nm, e);
    cyc({nm, "/exe"}, 4'd6, 4'b0000, e, alu, 2'b00, 1'b1, 2'b00, 2'b00);
    cyc({nm, "/aluwb"}, 4'd7, 4'b0010, e, 3'd0, 2'b00, 1'b0, 2'b00, 2'b01);
    exp_cnt++;
  endtask

  task automatic do_beq(input logic z);
    op = 6'b000100;
    zero = z;
    fd(z ? "beq1" : "beq0", 2'b01);
    cyc(z ? "beq1/branch" : "beq0/branch", 4'd8, z ? 4'b1000 : 4'b0000, 2'b01, 3'd2, 2'b01,
        1'b0, 2'b00, 2'b00);
    exp_cnt++;
    zero = 1'b0;
  endtask

  task automatic do_jump(input bit link);
    op = link ? 6'b000011 : 6'b000010;
    fd(link ? "jal" : "j", 2'b01);
    cyc(link ? "jal/jump" : "j/jump", 4'd9, link ? 4'b1010 : 4'b1000, 2'b01, 3'd0, 2'b10,
        1'b0, link ? 2'b10 : 2'b00, link ? 2'b10 : 2'b00);
    exp_cnt++;
  endtask

  task automatic do_illegal(input string nm, input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    fd(nm, 2'b01);
    exp_ill = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 4'd0, 4'b0000, 2'b01, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00);
    rst = 1'b1;
    do_lw();
    do_sw(1'b0);
    do_r("addu", 6'b100001, 3'd1);
    do_r("subu", 6'b100011, 3'd2);
    do_r("and", 6'b100100, 3'd3);
    do_r("or", 6'b100101, 3'd4);
    do_r("slt", 6'b101010, 3'd5);
    do_i("lui", 6'b001111, 2'b10, 3'd4);
    do_i("ori", 6'b001101, 2'b00, 3'd4);
    do_i("addiu", 6'b001001, 2'b01, 3'd1);
    do_beq(1'b1);
    do_beq(1'b0);
    do_jump(1'b1);
    do_jump(1'b0);
    do_illegal("ill_op", 6'b111111, 6'b000000);
    do_illegal("ill_fn", 6'b000000, 6'b000000);
    do_lw();
    do_sw(1'b1);
    do_jump(1'b0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
